cache_mem_arbiter: RTL and testbench

Responder side of the cache/memory interface: it services instruction-fetch requests from the icache (`iREN`/`iaddr` → `iwait`/`iload`) and data requests from the dcache, and arbitrates both onto a single-port RAM. It sits between the caches and the RAM model, holds each granted transaction until the RAM reports completion, and optionally prefetches the next sequential instruction word.

---
 rtl/cpu_types_pkg.sv | 16 +
 rtl/diaosi_types_pkg.sv | 25 ++
 rtl/iprefetch_buf.sv | 52 +++++
 rtl/cache_mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU word and RAM handshake types
//
// word_t     : 32-bit machine word
// ramstate_t : RAM status reported back to the arbiter each cycle
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/diaosi_types_pkg.sv
// rtl/diaosi_types_pkg.sv - memory arbiter state encoding and constants
//
// Optional feature macro: MEMARB_IPREFETCH_EN adds the ARB_PF state.
package diaosi_types_pkg;
    import cpu_types_pkg::*;

    // Byte distance between consecutive instruction words.
    localparam word_t IADDR_STEP = 32'd4;

`ifdef MEMARB_IPREFETCH_EN
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_DACC = 2'd1,
        ARB_IACC = 2'd2,
        ARB_PF   = 2'd3
    } memarb_state_t;
`else
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_DACC = 2'd1,
        ARB_IACC = 2'd2
    } memarb_state_t;
`endif

endpackage

// File: rtl/iprefetch_buf.sv
// rtl/iprefetch_buf.sv - one-entry sequential instruction prefetch buffer
//
// Used only when MEMARB_IPREFETCH_EN is defined.
// Ports:
//   CLK, nRST   : clock, asynchronous active-low reset
//   start       : begin a new prefetch of start_addr (entry becomes invalid)
//   fill        : prefetch read completed, capture fill_data and mark valid
//   wr_done     : a data write completed to wr_addr (invalidates on match)
//   lookup_addr : instruction address compared against the entry
//   hit         : entry valid and lookup_addr matches
//   pf_addr     : address of the entry (also the address being prefetched)
//   pf_data     : captured instruction word
module iprefetch_buf
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  start,
    input  word_t start_addr,
    input  logic  fill,
    input  word_t fill_data,
    input  logic  wr_done,
    input  word_t wr_addr,
    input  word_t lookup_addr,
    output logic  hit,
    output word_t pf_addr,
    output word_t pf_data
);

    logic pf_valid;

    // start, fill and wr_done come from mutually exclusive arbiter states,
    // so the priority order below only matters for robustness.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pf_addr  <= '0;
            pf_data  <= '0;
            pf_valid <= 1'b0;
        end else if (start) begin
            pf_addr  <= start_addr;
            pf_valid <= 1'b0;
        end else if (fill) begin
            pf_data  <= fill_data;
            pf_valid <= 1'b1;
        end else if (wr_done && (wr_addr == pf_addr)) begin
            pf_valid <= 1'b0;
        end
    end

    assign hit = pf_valid && (lookup_addr == pf_addr);

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - icache/dcache to single-port RAM arbiter
//
// Optional feature macro: MEMARB_IPREFETCH_EN (one-entry instruction prefetch).
// Ports:
//   CLK, nRST           : clock, asynchronous active-low reset
//   iREN, iaddr         : icache read request and word address
//   iwait, iload        : icache completion (0 = done this cycle) and data
//   dREN, dWEN          : dcache read / write request
//   daddr, dstore       : dcache address and write data
//   dwait, dload        : dcache completion and read data
//   ramREN, ramWEN      : RAM strobes
//   ramaddr, ramstore   : RAM address and write data
//   ramload, ramstate   : RAM read data and status
module cache_mem_arbiter
    import cpu_types_pkg::*;
    import diaosi_types_pkg::*;
(
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    memarb_state_t state, state_next;
    logic          dreq;

    assign dreq = dREN | dWEN;

`ifdef MEMARB_IPREFETCH_EN
    logic  pf_hit;
    logic  pf_start;
    logic  pf_fill;
    logic  pf_wr_done;
    word_t pf_addr;
    word_t pf_data;

    assign pf_wr_done = (state == ARB_DACC) && dWEN && (ramstate == ACCESS);

    iprefetch_buf u_iprefetch_buf (
        .CLK         (CLK),
        .nRST        (nRST),
        .start       (pf_start),
        .start_addr  (iaddr + IADDR_STEP),
        .fill        (pf_fill),
        .fill_data   (ramload),
        .wr_done     (pf_wr_done),
        .wr_addr     (daddr),
        .lookup_addr (iaddr),
        .hit         (pf_hit),
        .pf_addr     (pf_addr),
        .pf_data     (pf_data)
    );
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        iwait      = 1'b1;
        iload      = '0;
        dwait      = 1'b1;
        dload      = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
`ifdef MEMARB_IPREFETCH_EN
        pf_start   = 1'b0;
        pf_fill    = 1'b0;
`endif
        case (state)
            ARB_IDLE: begin
                if (dreq) begin
                    state_next = ARB_DACC;
                end
`ifdef MEMARB_IPREFETCH_EN
                // A buffer hit completes without touching RAM and
                // immediately starts fetching the following word.
                else if (iREN && pf_hit) begin
                    iwait      = 1'b0;
                    iload      = pf_data;
                    pf_start   = 1'b1;
                    state_next = ARB_PF;
                end
`endif
                else if (iREN) begin
                    state_next = ARB_IACC;
                end
            end

            ARB_DACC: begin
                // Requester withdrew: strobes stay low, nothing completes.
                if (!dreq) begin
                    state_next = ARB_IDLE;
                end else begin
                    ramREN   = dREN;
                    ramWEN   = dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    if (ramstate == ACCESS) begin
                        dwait      = 1'b0;
                        dload      = ramload;
                        state_next = ARB_IDLE;
                    end else if (ramstate == ERROR) begin
                        // Re-arbitrate; the held request is retried.
                        state_next = ARB_IDLE;
                    end
                end
            end

            ARB_IACC: begin
                if (!iREN) begin
                    state_next = ARB_IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ramstate == ACCESS) begin
                        iwait      = 1'b0;
                        iload      = ramload;
                        state_next = ARB_IDLE;
`ifdef MEMARB_IPREFETCH_EN
                        if (!dreq) begin
                            pf_start   = 1'b1;
                            state_next = ARB_PF;
                        end
`endif
                    end else if (ramstate == ERROR) begin
                        state_next = ARB_IDLE;
                    end
                end
            end

`ifdef MEMARB_IPREFETCH_EN
            ARB_PF: begin
                // Data traffic always wins; an aborted prefetch stays invalid.
                if (dreq) begin
                    state_next = ARB_IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = pf_addr;
                    if (ramstate == ACCESS) begin
                        pf_fill    = 1'b1;
                        state_next = ARB_IDLE;
                    end else if (ramstate == ERROR) begin
                        state_next = ARB_IDLE;
                    end
                end
            end
`endif

            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed vector bench for cache_mem_arbiter
module tb_cache_mem_arbiter;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore;
    logic      iwait, dwait, ramREN, ramWEN;
    word_t     iload, dload, ramaddr, ramstore, ramload;
    ramstate_t ramstate;

    word_t     vec_rload;
    logic      ram_model_en;
    word_t     mem [0:255];

    int applied     = 0;
    int miscompares = 0;

    typedef struct {
        string     name;
        logic      iren;
        word_t     ia;
        logic      dren;
        logic      dwen;
        word_t     da;
        word_t     ds;
        ramstate_t rs;
        word_t     rl;
        logic      eiw;
        word_t     eil;
        logic      edw;
        word_t     edl;
        logic      err;
        logic      erw;
        word_t     era;
        word_t     ers;
    } vec_t;

    vec_t vecs[$];

    cache_mem_arbiter dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    always #5 CLK = ~CLK;

    assign ramload = ram_model_en ? mem[ramaddr[9:2]] : vec_rload;

    always @(posedge CLK) begin
        if (ram_model_en && ramWEN && (ramstate == ACCESS))
            mem[ramaddr[9:2]] <= ramstore;
    end

    task automatic add(input string nm, input logic iren, input word_t ia,
                       input logic dren, input logic dwen, input word_t da, input word_t ds,
                       input ramstate_t rs, input word_t rl,
                       input logic eiw, input word_t eil, input logic edw, input word_t edl,
                       input logic err, input logic erw, input word_t era, input word_t ers);
        vec_t v;
        v.name = nm; v.iren = iren; v.ia = ia; v.dren = dren; v.dwen = dwen;
        v.da = da; v.ds = ds; v.rs = rs; v.rl = rl;
        v.eiw = eiw; v.eil = eil; v.edw = edw; v.edl = edl;
        v.err = err; v.erw = erw; v.era = era; v.ers = ers;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic iren, input word_t ia, input logic dren, input logic dwen,
                         input word_t da, input word_t ds, input ramstate_t rs, input word_t rl);
        iREN = iren; iaddr = ia; dREN = dren; dWEN = dwen;
        daddr = da; dstore = ds; ramstate = rs; vec_rload = rl;
    endtask

    // Drive at the falling edge, sample 1 ns later, well away from the rising edge.
    task automatic cyc(input logic iren, input word_t ia, input logic dren, input logic dwen,
                       input word_t da, input word_t ds, input ramstate_t rs, input word_t rl);
        @(negedge CLK);
        drive(iren, ia, dren, dwen, da, ds, rs, rl);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic eiw, input word_t eil,
                              input logic edw, input word_t edl, input logic err,
                              input logic erw, input word_t era, input word_t ers);
        applied++;
        if ({iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore} !==
            {eiw, eil, edw, edl, err, erw, era, ers}) begin
            miscompares++;
            $display("FAIL %s: got iwait=%b iload=%h dwait=%b dload=%h ramREN=%b ramWEN=%b ramaddr=%h ramstore=%h ; want iwait=%b iload=%h dwait=%b dload=%h ramREN=%b ramWEN=%b ramaddr=%h ramstore=%h",
                     nm, iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
                     eiw, eil, edw, edl, err, erw, era, ers);
        end
    endtask

    task automatic expect_idle(input string nm);
        expect_out(nm, 1'b1, '0, 1'b1, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        ram_model_en = 1'b0;
        nRST = 1'b0;
        drive(0, 0, 0, 0, 0, 0, FREE, 0);
        #1;
        expect_idle("reset");
        @(negedge CLK);
        nRST = 1'b1;

`ifndef MEMARB_IPREFETCH_EN
        //   name          iREN iaddr       dREN dWEN daddr   dstore    ramstate ramload        iwait iload        dwait dload        REN WEN addr     store
        add("idle",        0, 32'h0,   0, 0, 32'h0,   32'h0,    FREE,   32'h0,         1, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0);
        add("i40_req",     1, 32'h40,  0, 0, 32'h0,   32'h0,    FREE,   32'h0,         1, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0);
        add("i40_busy1",   1, 32'h40,  0, 0, 32'h0,   32'h0,    BUSY,   32'h0,         1, 32'h0,        1, 32'h0,        1, 0, 32'h40,  32'h0);
        add("i40_busy2",   1, 32'h40,  0, 0, 32'h0,   32'h0,    BUSY,   32'h0,         1, 32'h0,        1, 32'h0,        1, 0, 32'h40,  32'h0);
        add("i40_done",    1, 32'h40,  0, 0, 32'h0,   32'h0,    ACCESS, 32'hDEADBEEF,  0, 32'hDEADBEEF, 1, 32'h0,        1, 0, 32'h40,  32'h0);
        add("i40_after",   0, 32'h0,   0, 0, 32'h0,   32'h0,    FREE,   32'h0,         1, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0);
        add("err_req",     1, 32'h80,  0, 0, 32'h0,   32'h0,    FREE,   32'h0,         1, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0);
        add("err_cyc",     1, 32'h80,  0, 0, 32'h0,   32'h0,    ERROR,  32'h5555,      1, 32'h0,        1, 32'h0,        1, 0, 32'h80,  32'h0);
        add("err_rearb",   1, 32'h80,  0, 0, 32'h0,   32'h0,    FREE,   32'h0,         1, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0);
        add("err_retry",   1, 32'h80,  0, 0, 32'h0,   32'h0,    ACCESS, 32'h12345678,  0, 32'h12345678, 1, 32'h0,        1, 0, 32'h80,  32'h0);
        add("err_after",   0, 32'h0,   0, 0, 32'h0,   32'h0,    FREE,   32'h0,         1, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0);
        add("drop_req",    1, 32'hC0,  0, 0, 32'h0,   32'h0,    FREE,   32'h0,         1, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0);
        add("drop_busy",   1, 32'hC0,  0, 0, 32'h0,   32'h0,    BUSY,   32'h0,         1, 32'h0,        1, 32'h0,        1, 0, 32'hC0,  32'h0);
        add("drop_cyc",    0, 32'hC0,  0, 0, 32'h0,   32'h0,    ACCESS, 32'hAAAA,      1, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0);
        add("drop_idle",   1, 32'hC0,  0, 0, 32'h0,   32'h0,    ACCESS, 32'hAAAA,      1, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0);
        add("drop_end",    0, 32'h0,   0, 0, 32'h0,   32'h0,    FREE,   32'h0,         1, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0);
        add("pri_req",     1, 32'h300, 1, 0, 32'h200, 32'h0,    FREE,   32'h0,         1, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0);
        add("pri_busy",    1, 32'h300, 1, 0, 32'h200, 32'h0,    BUSY,   32'h0,         1, 32'h0,        1, 32'h0,        1, 0, 32'h200, 32'h0);
        add("pri_ddone",   1, 32'h300, 1, 0, 32'h200, 32'h0,    ACCESS, 32'h0BADF00D,  1, 32'h0,        0, 32'h0BADF00D, 1, 0, 32'h200, 32'h0);
        add("pri_gap",     1, 32'h300, 0, 0, 32'h0,   32'h0,    FREE,   32'h0,         1, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0);
        add("pri_idone",   1, 32'h300, 0, 0, 32'h0,   32'h0,    ACCESS, 32'h11,        0, 32'h11,       1, 32'h0,        1, 0, 32'h300, 32'h0);
        add("pri_after",   0, 32'h0,   0, 0, 32'h0,   32'h0,    FREE,   32'h0,         1, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0);
        add("wr_req",      0, 32'h0,   0, 1, 32'h400, 32'hCAFE, FREE,   32'h0,         1, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0);
        add("wr_err",      0, 32'h0,   0, 1, 32'h400, 32'hCAFE, ERROR,  32'h77,        1, 32'h0,        1, 32'h0,        0, 1, 32'h400, 32'hCAFE);
        add("wr_rearb",    0, 32'h0,   0, 1, 32'h400, 32'hCAFE, FREE,   32'h0,         1, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0);
        add("wr_done",     0, 32'h0,   0, 1, 32'h400, 32'hCAFE, ACCESS, 32'h0,         1, 32'h0,        0, 32'h0,        0, 1, 32'h400, 32'hCAFE);
        add("wr_after",    0, 32'h0,   0, 0, 32'h0,   32'h0,    FREE,   32'h0,         1, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0);
        add("dd_req",      0, 32'h0,   1, 0, 32'h500, 32'h0,    FREE,   32'h0,         1, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0);
        add("dd_busy",     0, 32'h0,   1, 0, 32'h500, 32'h0,    BUSY,   32'h0,         1, 32'h0,        1, 32'h0,        1, 0, 32'h500, 32'h0);
        add("dd_drop",     0, 32'h0,   0, 0, 32'h500, 32'h0,    ACCESS, 32'h9,         1, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0);
        add("dd_after",    0, 32'h0,   0, 0, 32'h0,   32'h0,    FREE,   32'h0,         1, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0);
        add("np_req",      1, 32'h600, 0, 0, 32'h0,   32'h0,    FREE,   32'h0,         1, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0);
        add("np_busy",     1, 32'h600, 1, 0, 32'h700, 32'h0,    BUSY,   32'h0,         1, 32'h0,        1, 32'h0,        1, 0, 32'h600, 32'h0);
        add("np_idone",    1, 32'h600, 1, 0, 32'h700, 32'h0,    ACCESS, 32'h66,        0, 32'h66,       1, 32'h0,        1, 0, 32'h600, 32'h0);
        add("np_dgap",     0, 32'h0,   1, 0, 32'h700, 32'h0,    FREE,   32'h0,         1, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0);
        add("np_ddone",    0, 32'h0,   1, 0, 32'h700, 32'h0,    ACCESS, 32'h77,        1, 32'h0,        0, 32'h77,       1, 0, 32'h700, 32'h0);
        add("np_after",    0, 32'h0,   0, 0, 32'h0,   32'h0,    FREE,   32'h0,         1, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0);

        foreach (vecs[i]) begin
            cyc(vecs[i].iren, vecs[i].ia, vecs[i].dren, vecs[i].dwen,
                vecs[i].da, vecs[i].ds, vecs[i].rs, vecs[i].rl);
            expect_out(vecs[i].name, vecs[i].eiw, vecs[i].eil, vecs[i].edw, vecs[i].edl,
                       vecs[i].err, vecs[i].erw, vecs[i].era, vecs[i].ers);
        end

        // Simultaneous write and fetch against a zero-wait RAM model, then read back.
        ram_model_en = 1'b1;
        mem[65] = 32'h77;
        cyc(1, 32'h104, 0, 1, 32'h100, 32'h5, ACCESS, 0);
        expect_idle("sim_idle");
        cyc(1, 32'h104, 0, 1, 32'h100, 32'h5, ACCESS, 0);
        expect_out("sim_write", 1, 32'h0, 0, 32'h0, 0, 1, 32'h100, 32'h5);
        cyc(1, 32'h104, 0, 0, 32'h0, 32'h0, ACCESS, 0);
        expect_idle("sim_gap");
        cyc(1, 32'h104, 0, 0, 32'h0, 32'h0, ACCESS, 0);
        expect_out("sim_fetch", 0, 32'h77, 1, 32'h0, 1, 0, 32'h104, 32'h0);
        cyc(0, 32'h0, 1, 0, 32'h100, 32'h0, ACCESS, 0);
        expect_idle("rb_idle");
        cyc(0, 32'h0, 1, 0, 32'h100, 32'h0, ACCESS, 0);
        expect_out("rb_read", 1, 32'h0, 0, 32'h5, 1, 0, 32'h100, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, FREE, 0);
        expect_idle("rb_after");
        ram_model_en = 1'b0;

        // Reset in the middle of a fetch drops the strobes without waiting for a clock.
        cyc(1, 32'h40, 0, 0, 0, 0, BUSY, 0);
        expect_idle("rst_req");
        cyc(1, 32'h40, 0, 0, 0, 0, BUSY, 0);
        expect_out("rst_pre", 1, 32'h0, 1, 32'h0, 1, 0, 32'h40, 32'h0);
        #2;
        nRST = 1'b0;
        #1;
        expect_idle("rst_async");
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        expect_idle("rst_release");
        cyc(0, 0, 0, 0, 0, 0, FREE, 0);
        expect_idle("rst_after");
`else
        // Prefetch: sequential hit, then invalidation by a data write.
        ram_model_en = 1'b1;
        mem[16] = 32'hA0;
        mem[17] = 32'hA4;
        mem[18] = 32'hA8;
        cyc(1, 32'h40, 0, 0, 0, 0, ACCESS, 0);
        expect_idle("pf_req");
        cyc(1, 32'h40, 0, 0, 0, 0, ACCESS, 0);
        expect_out("pf_fetch40", 0, 32'hA0, 1, 32'h0, 1, 0, 32'h40, 32'h0);
        cyc(0, 32'h0, 0, 0, 0, 0, ACCESS, 0);
        expect_out("pf_read44", 1, 32'h0, 1, 32'h0, 1, 0, 32'h44, 32'h0);
        cyc(1, 32'h44, 0, 0, 0, 0, ACCESS, 0);
        expect_out("pf_hit44", 0, 32'hA4, 1, 32'h0, 0, 0, 32'h0, 32'h0);
        cyc(0, 32'h0, 0, 0, 0, 0, ACCESS, 0);
        expect_out("pf_read48", 1, 32'h0, 1, 32'h0, 1, 0, 32'h48, 32'h0);
        cyc(0, 32'h0, 0, 1, 32'h48, 32'h99, ACCESS, 0);
        expect_idle("pf_wr_req");
        cyc(0, 32'h0, 0, 1, 32'h48, 32'h99, ACCESS, 0);
        expect_out("pf_wr48", 1, 32'h0, 0, 32'hA8, 0, 1, 32'h48, 32'h99);
        cyc(1, 32'h48, 0, 0, 0, 0, ACCESS, 0);
        expect_idle("pf_miss48");
        cyc(1, 32'h48, 0, 0, 0, 0, ACCESS, 0);
        expect_out("pf_fetch48", 0, 32'h99, 1, 32'h0, 1, 0, 32'h48, 32'h0);
        cyc(0, 32'h0, 0, 0, 0, 0, ACCESS, 0);
        expect_out("pf_read4c", 1, 32'h0, 1, 32'h0, 1, 0, 32'h4C, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, FREE, 0);
        expect_idle("pf_after");
        ram_model_en = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
